// File: rtl/ccff_chain_loader.sv
// Programming controller for a configuration flip-flop chain: serialises bitstream words
// MSB-first into the chain, then rotates it once through the tail-to-head loopback and compares CRCs.
module ccff_chain_loader #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [CNT_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int          BL_W     = $clog2(WORD_W + 1);
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_bit_count;
    logic [WORD_W-1:0]  r_buf;
    logic [BL_W-1:0]    r_bits_left;
    logic [15:0]        r_crc_ld;
    logic [15:0]        r_crc_rb;
    logic               r_error;
    logic               r_err_forced;

    logic               w_shifting;
    logic               w_accept;
    logic               w_last_bit;
    logic [CNT_W-1:0]   w_bit_count_inc;

    // CRC-16-CCITT, one bit per call, MSB-first feedback.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    // NOTE: every output gets its default before the case so no path can leave one unassigned (no latch).
    always_comb begin
        w_shifting      = (r_state == S_LOAD) && (r_bits_left != '0);
        w_bit_count_inc = r_bit_count + CNT_W'(1);
        w_last_bit      = (w_bit_count_inc == r_len);
        word_ready      = (r_state == S_LOAD) &&
                          ((r_bits_left == '0) || ((r_bits_left == BL_W'(1)) && w_shifting));
        w_accept        = word_valid && word_ready;
        busy            = (r_state != S_IDLE);
        bit_count       = r_bit_count;

        chain_clk_en = 1'b0;
        ccff_head    = 1'b0;
        done         = 1'b0;
        error        = r_error;
        w_state_nxt  = r_state;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (chain_len == '0) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                // An empty buffer stalls the chain: clock gated, head parked at 0.
                if (w_shifting) begin
                    chain_clk_en = 1'b1;
                    ccff_head    = r_buf[WORD_W-1];
                    if (w_last_bit) begin
                        w_state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                chain_clk_en = 1'b1;
                ccff_head    = ccff_tail;
                if (w_last_bit) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                done        = 1'b1;
                error       = r_err_forced || (r_crc_ld != r_crc_rb);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of order.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_bit_count  <= '0;
            r_buf        <= '0;
            r_bits_left  <= '0;
            r_crc_ld     <= CRC_INIT;
            r_crc_rb     <= CRC_INIT;
            r_error      <= 1'b0;
            r_err_forced <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len        <= chain_len;
                        r_error      <= 1'b0;
                        r_err_forced <= (chain_len == '0);
                        r_bit_count  <= '0;
                        r_buf        <= '0;
                        r_bits_left  <= '0;
                        r_crc_ld     <= CRC_INIT;
                        r_crc_rb     <= CRC_INIT;
                    end
                end
                S_LOAD: begin
                    if (w_shifting) begin
                        r_crc_ld <= crc16_step(r_crc_ld, r_buf[WORD_W-1]);
                        if (w_last_bit) begin
                            // Chain is full: drop any unshifted tail of the last word.
                            r_buf       <= '0;
                            r_bits_left <= '0;
                            r_bit_count <= '0;
                        end else begin
                            r_bit_count <= w_bit_count_inc;
                            if (w_accept) begin
                                r_buf       <= word_data;
                                r_bits_left <= BL_W'(WORD_W);
                            end else begin
                                r_buf       <= {r_buf[WORD_W-2:0], 1'b0};
                                r_bits_left <= r_bits_left - BL_W'(1);
                            end
                        end
                    end else if (w_accept) begin
                        r_buf       <= word_data;
                        r_bits_left <= BL_W'(WORD_W);
                    end
                end
                S_CHECK: begin
                    r_crc_rb    <= crc16_step(r_crc_rb, ccff_tail);
                    r_bit_count <= w_bit_count_inc;
                end
                S_FINISH: begin
                    r_error <= error;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: a behavioural shift-chain model closes the
// tail-to-head loop, and expected streams, latencies and CRC verdicts come from the word list.
module tb_ccff_chain_loader;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 16;
    localparam int BUDGET = 400;

    logic              prog_clk   = 1'b0;
    logic              pReset     = 1'b1;
    logic              start      = 1'b0;
    logic [CNT_W-1:0]  chain_len  = '0;
    logic [WORD_W-1:0] word_data  = '0;
    logic              word_valid = 1'b0;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_tail;
    logic              chain_clk_en;
    logic              busy;
    logic              done;
    logic              error;
    logic [CNT_W-1:0]  bit_count;

    int total = 0;
    int bad   = 0;

    ccff_chain_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .chain_len    (chain_len),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .chain_clk_en (chain_clk_en),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bit_count    (bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: shifts only on clock edges where the gate is enabled.
    logic [63:0] chain     = '0;
    logic [5:0]  model_idx = '0;
    logic        stuck0    = 1'b0;
    assign ccff_tail = stuck0 ? 1'b0 : chain[model_idx];
    always @(posedge prog_clk) if (chain_clk_en) chain <= {chain[62:0], ccff_head};

    // Words offered, and observations from the most recent run.
    logic [7:0] wq[$];
    logic       obs_head[$];
    int         obs_bc[$];
    int   o_first_en, o_low_span, o_head_bad, o_ready_idle, o_done_cnt, o_done_cyc, o_accepted;
    int   o_bc_done, o_rst_bc, o_rst_done_cnt;
    logic o_err_done, o_busy_after, o_err_c1;
    logic o_rst_busy, o_rst_en, o_rst_ready, o_rst_done;

    function automatic logic exp_bit(input int i);
        logic [7:0] w;
        w = wq[i / 8];
        return w[7 - (i % 8)];
    endfunction

    function automatic logic [15:0] crc_stream(input int len, input bit zeros);
        logic [15:0] c;
        logic        b;
        c = 16'hFFFF;
        for (int i = 0; i < len; i++) begin
            b = zeros ? 1'b0 : exp_bit(i);
            c = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic int head_errs(input int len);
        int n = 0;
        for (int i = 0; i < len; i++)
            if (i >= obs_head.size() || obs_head[i] !== exp_bit(i)) n++;
        return n;
    endfunction

    function automatic int chain_errs(input int len);
        int n = 0;
        for (int i = 0; i < len; i++)
            if (chain[len - 1 - i] !== exp_bit(i)) n++;
        return n;
    endfunction

    function automatic int bc_errs(input int len);
        int n = 0;
        for (int j = 0; j < obs_bc.size(); j++)
            if (obs_bc[j] != ((j < len) ? j : j - len)) n++;
        return n;
    endfunction

    task automatic do_load(input int len, input int stall_idx, input int stall_n,
                           input bit rand_gaps, input int reset_at);
        int idx = 0;
        int gap = stall_n;
        int pending = 0;
        bit hold, v;
        obs_head.delete();
        obs_bc.delete();
        o_first_en = -1; o_low_span = 0; o_head_bad = 0; o_ready_idle = 0;
        o_done_cnt = 0; o_done_cyc = -1; o_accepted = 0; o_busy_after = 1'b1;
        o_rst_done_cnt = 0; o_err_done = 1'bx; o_bc_done = -1;
        model_idx = (len > 0) ? 6'(len - 1) : 6'd0;
        @(negedge prog_clk);
        start = 1'b1; chain_len = CNT_W'(len); word_valid = 1'b0;
        @(negedge prog_clk);
        start = 1'b0; chain_len = CNT_W'($urandom_range(1, 50));
        for (int cyc = 1; cyc < BUDGET; cyc++) begin
            if (cyc == 1) o_err_c1 = error;
            if (chain_clk_en) begin
                obs_head.push_back(ccff_head);
                obs_bc.push_back(int'(bit_count));
                if (o_first_en >= 0) o_low_span += pending;
                else o_first_en = cyc;
                pending = 0;
            end else begin
                if (o_first_en >= 0) pending++;
                if (busy && ccff_head) o_head_bad++;
            end
            if (word_ready && !busy) o_ready_idle++;
            if (done) begin
                o_done_cnt++;
                if (o_done_cyc < 0) begin
                    o_done_cyc = cyc; o_err_done = error; o_bc_done = int'(bit_count);
                end
            end
            if (o_done_cyc >= 0 && cyc == o_done_cyc + 1) o_busy_after = busy;
            if (reset_at >= 0 && chain_clk_en && int'(bit_count) == reset_at &&
                obs_head.size() == reset_at + 1) begin
                pReset = 1'b1; word_valid = 1'b0;
                @(negedge prog_clk);
                o_rst_busy = busy; o_rst_en = chain_clk_en; o_rst_ready = word_ready;
                o_rst_bc = int'(bit_count); o_rst_done = done;
                pReset = 1'b0;
                repeat (80) begin
                    @(negedge prog_clk);
                    if (done) o_rst_done_cnt++;
                end
                return;
            end
            if (o_done_cyc >= 0 && cyc >= o_done_cyc + 3) break;
            hold = (idx == stall_idx) && (gap > 0);
            if (hold && word_ready) gap--;
            v = (idx < wq.size()) && !hold && (!rand_gaps || $urandom_range(0, 3) != 0);
            word_valid = v;
            word_data  = v ? wq[idx] : 8'($urandom);
            if (v && word_ready) begin
                idx++; o_accepted++;
            end
            @(negedge prog_clk);
        end
        word_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge prog_clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (word_ready !== 1'b0) begin bad++; $display("FAIL rst_word_ready: got %b expected 0", word_ready); end
        total++; if (chain_clk_en !== 1'b0) begin bad++; $display("FAIL rst_clk_en: got %b expected 0", chain_clk_en); end
        total++; if (ccff_head !== 1'b0) begin bad++; $display("FAIL rst_head: got %b expected 0", ccff_head); end
        total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_done_error: got %b%b expected 00", done, error); end
        total++; if (bit_count !== '0) begin bad++; $display("FAIL rst_bit_count: got %0d expected 0", bit_count); end
        pReset = 1'b0;
        word_valid = 1'b1; word_data = 8'h5A;
        repeat (3) @(negedge prog_clk);
        total++; if (word_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_accept: ready=%b busy=%b expected 0 0", word_ready, busy); end
        word_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C); wq.push_back(8'hF0); wq.push_back(8'h0F);
        stuck0 = 1'b0;
        do_load(32, -1, 0, 1'b0, -1);
        total++; if (head_errs(32) != 0) begin bad++; $display("FAIL b2b_head_stream: %0d wrong bits expected 0", head_errs(32)); end
        total++; if (obs_head.size() != 64 || o_low_span != 0) begin bad++; $display("FAIL b2b_clk_en: high=%0d gaps=%0d expected 64 0", obs_head.size(), o_low_span); end
        total++; if (o_done_cyc != 66) begin bad++; $display("FAIL b2b_latency: got %0d expected 66", o_done_cyc); end
        total++; if (o_err_done !== 1'b0 || o_done_cnt != 1) begin bad++; $display("FAIL b2b_done: error=%b pulses=%0d expected 0 1", o_err_done, o_done_cnt); end
        total++; if (chain_errs(32) != 0) begin bad++; $display("FAIL b2b_chain: %0d wrong bits expected 0", chain_errs(32)); end
        total++; if (o_accepted != 4) begin bad++; $display("FAIL b2b_accepted: got %0d expected 4", o_accepted); end
        total++; if (bc_errs(32) != 0 || o_bc_done != 32) begin bad++; $display("FAIL b2b_bit_count: errs=%0d at_done=%0d expected 0 32", bc_errs(32), o_bc_done); end
        total++; if (o_ready_idle != 0 || o_busy_after !== 1'b0) begin bad++; $display("FAIL b2b_idle: ready_idle=%0d busy_after=%b expected 0 0", o_ready_idle, o_busy_after); end
    endtask

    task automatic test_stall();
        do_load(32, 2, 5, 1'b0, -1);
        total++; if (o_low_span != 5 || obs_head.size() != 64) begin bad++; $display("FAIL stall_gaps: gaps=%0d high=%0d expected 5 64", o_low_span, obs_head.size()); end
        total++; if (o_head_bad != 0) begin bad++; $display("FAIL stall_head_parked: got %0d expected 0", o_head_bad); end
        total++; if (o_done_cyc != 71 || o_err_done !== 1'b0) begin bad++; $display("FAIL stall_done: cycle=%0d error=%b expected 71 0", o_done_cyc, o_err_done); end
        total++; if (head_errs(32) != 0 || chain_errs(32) != 0) begin bad++; $display("FAIL stall_data: head=%0d chain=%0d expected 0 0", head_errs(32), chain_errs(32)); end
    endtask

    task automatic test_partial_word();
        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'hC0); wq.push_back(8'h55);
        do_load(10, -1, 0, 1'b0, -1);
        total++; if (head_errs(10) != 0) begin bad++; $display("FAIL partial_head: %0d wrong bits expected 0", head_errs(10)); end
        total++; if (o_accepted != 2) begin bad++; $display("FAIL partial_accepted: got %0d expected 2", o_accepted); end
        total++; if (o_done_cyc != 22 || o_err_done !== 1'b0) begin bad++; $display("FAIL partial_done: cycle=%0d error=%b expected 22 0", o_done_cyc, o_err_done); end
        total++; if (obs_head.size() != 20 || chain_errs(10) != 0) begin bad++; $display("FAIL partial_chain: high=%0d errs=%0d expected 20 0", obs_head.size(), chain_errs(10)); end
    endtask

    task automatic test_stuck_tail();
        logic exp_err;
        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'hFF);
        stuck0  = 1'b1;
        exp_err = (crc_stream(16, 1'b0) != crc_stream(16, 1'b1));
        do_load(16, -1, 0, 1'b0, -1);
        total++; if (o_err_done !== exp_err || o_done_cnt != 1) begin bad++; $display("FAIL stuck_error: error=%b pulses=%0d expected %b 1", o_err_done, o_done_cnt, exp_err); end
        repeat (5) @(negedge prog_clk);
        total++; if (error !== 1'b1) begin bad++; $display("FAIL stuck_error_held: got %b expected 1", error); end
        stuck0 = 1'b0;
        do_load(16, -1, 0, 1'b0, -1);
        total++; if (o_err_c1 !== 1'b0) begin bad++; $display("FAIL stuck_error_cleared: got %b expected 0", o_err_c1); end
        total++; if (o_err_done !== 1'b0 || chain_errs(16) != 0) begin bad++; $display("FAIL stuck_reload: error=%b chain=%0d expected 0 0", o_err_done, chain_errs(16)); end
    endtask

    task automatic test_zero_len();
        int   en_cnt = 0;
        int   dcnt = 0;
        int   dcyc = -1;
        logic derr = 1'b0;
        logic busy_late = 1'b1;
        @(negedge prog_clk);
        start = 1'b1; chain_len = '0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge prog_clk);
            if (chain_clk_en) en_cnt++;
            if (done) begin
                dcnt++;
                if (dcyc < 0) begin dcyc = cyc; derr = error; end
            end
            if (cyc == 4) busy_late = busy;
            start = (cyc == 1);
            chain_len = CNT_W'(5);
        end
        start = 1'b0;
        total++; if (en_cnt != 0) begin bad++; $display("FAIL zero_clk_en: got %0d cycles expected 0", en_cnt); end
        total++; if (dcnt != 1 || dcyc < 1 || dcyc > 2) begin bad++; $display("FAIL zero_done: pulses=%0d cycle=%0d expected 1 within 2", dcnt, dcyc); end
        total++; if (derr !== 1'b1) begin bad++; $display("FAIL zero_error: got %b expected 1", derr); end
        total++; if (busy_late !== 1'b0) begin bad++; $display("FAIL zero_second_start: busy=%b expected 0", busy_late); end
    endtask

    task automatic test_reset_mid_load();
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(8'($urandom));
        do_load(32, -1, 0, 1'b0, 7);
        total++; if (o_rst_busy !== 1'b0 || o_rst_en !== 1'b0 || o_rst_ready !== 1'b0) begin bad++; $display("FAIL midrst_outputs: busy=%b en=%b ready=%b expected 0 0 0", o_rst_busy, o_rst_en, o_rst_ready); end
        total++; if (o_rst_bc != 0 || o_rst_done !== 1'b0 || o_rst_done_cnt != 0) begin bad++; $display("FAIL midrst_no_done: bc=%0d done=%b later=%0d expected 0 0 0", o_rst_bc, o_rst_done, o_rst_done_cnt); end
        do_load(32, -1, 0, 1'b0, -1);
        total++; if (o_done_cyc != 66 || o_err_done !== 1'b0) begin bad++; $display("FAIL midrst_reload: cycle=%0d error=%b expected 66 0", o_done_cyc, o_err_done); end
        total++; if (head_errs(32) != 0 || chain_errs(32) != 0) begin bad++; $display("FAIL midrst_data: head=%0d chain=%0d expected 0 0", head_errs(32), chain_errs(32)); end
    endtask

    task automatic test_random();
        int len, nw;
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(1, 40);
            nw  = (len + 7) / 8;
            wq.delete();
            for (int i = 0; i < nw; i++) wq.push_back(8'($urandom));
            do_load(len, -1, 0, 1'b1, -1);
            total++; if (head_errs(len) != 0 || chain_errs(len) != 0) begin bad++; $display("FAIL rand%0d_data: len=%0d head=%0d chain=%0d expected 0 0", it, len, head_errs(len), chain_errs(len)); end
            total++; if (obs_head.size() != 2 * len || o_accepted != nw) begin bad++; $display("FAIL rand%0d_counts: high=%0d words=%0d expected %0d %0d", it, obs_head.size(), o_accepted, 2 * len, nw); end
            total++; if (o_done_cyc != o_first_en + 2 * len + o_low_span) begin bad++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, o_done_cyc, o_first_en + 2 * len + o_low_span); end
            total++; if (o_err_done !== 1'b0 || o_done_cnt != 1 || bc_errs(len) != 0) begin bad++; $display("FAIL rand%0d_result: error=%b pulses=%0d bc_errs=%0d expected 0 1 0", it, o_err_done, o_done_cnt, bc_errs(len)); end
            total++; if (o_head_bad != 0 || o_ready_idle != 0) begin bad++; $display("FAIL rand%0d_stall: head=%0d ready_idle=%0d expected 0 0", it, o_head_bad, o_ready_idle); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_partial_word();
        test_stuck_tail();
        test_zero_len();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
